// File: rtl/spi_wb_host_pkg.sv
// Shared constants, byte-FSM state type and frame byte mux for the spiwishbone host.
package spi_wb_host_pkg;

    localparam logic [7:0]  CMD_READ  = 8'hA1;
    localparam logic [7:0]  CMD_WRITE = 8'hA2;
    localparam logic [15:0] LEN_WORD  = 16'h0004;

    localparam int IDX_CMD  = 0;
    localparam int IDX_ADR0 = 1;
    localparam int IDX_LEN0 = 5;
    localparam int IDX_DATA = 7;

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_CS_SETUP,
        BS_SHIFT_LO,
        BS_SHIFT_HI,
        BS_CS_HOLD,
        BS_GAP
    } byte_state_e;

    // Address goes out big-endian, write data little-endian, everything past the header is 0x00 on reads.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic we,
                                              input logic [31:0] adr, input logic [31:0] wdata);
        int i;
        i = int'(idx);
        frame_byte = 8'h00;
        if (i == IDX_CMD)
            frame_byte = we ? CMD_WRITE : CMD_READ;
        else if (i >= IDX_ADR0 && i < IDX_LEN0)
            frame_byte = adr[8*(IDX_LEN0-1-i) +: 8];
        else if (i == IDX_LEN0)
            frame_byte = LEN_WORD[15:8];
        else if (i == IDX_LEN0 + 1)
            frame_byte = LEN_WORD[7:0];
        else if (we && i >= IDX_DATA && i < IDX_DATA + 4)
            frame_byte = wdata[8*(i-IDX_DATA) +: 8];
    endfunction

endpackage

// File: rtl/spi_wb_host_if.sv
// Local command/response port of the SPI host.
interface spi_wb_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output cmd_valid, cmd_we, cmd_adr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_we, rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_adr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_we, rdata, busy
    );
endinterface

// File: rtl/spi_byte_shifter.sv
// Mode-3 MSB-first single-byte shifter; frames each byte with its own CS-low window and gap.
module spi_byte_shifter
    import spi_wb_host_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int BYTE_GAP = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic [7:0] o_rx_byte,
    output logic       o_done,
    output logic       o_sclk,
    output logic       o_cs,
    output logic       o_mosi
);
    localparam int CNT_MAX = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    byte_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d;
    logic             sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
    logic             hdiv_end, gap_end;

    assign hdiv_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign gap_end  = (cnt_q == CNT_W'(BYTE_GAP - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        o_done  = 1'b0;
        case (state_q)
            BS_IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    state_d = BS_CS_SETUP;
                    cs_d    = 1'b0;
                    tx_d    = i_tx_byte;
                end
            end
            BS_CS_SETUP: if (hdiv_end) begin
                cnt_d   = '0;
                state_d = BS_SHIFT_LO;
                sclk_d  = 1'b0;
                mosi_d  = tx_q[7];
                bit_d   = '0;
            end
            // MISO is captured on the same clock that raises SCLK.
            BS_SHIFT_LO: if (hdiv_end) begin
                cnt_d   = '0;
                state_d = BS_SHIFT_HI;
                sclk_d  = 1'b1;
                rx_d    = {rx_q[6:0], i_miso};
            end
            BS_SHIFT_HI: if (hdiv_end) begin
                cnt_d = '0;
                if (bit_q == 3'd7) begin
                    state_d = BS_CS_HOLD;
                end else begin
                    state_d = BS_SHIFT_LO;
                    sclk_d  = 1'b0;
                    tx_d    = {tx_q[6:0], 1'b0};
                    mosi_d  = tx_q[6];
                    bit_d   = bit_q + 3'd1;
                end
            end
            BS_CS_HOLD: if (hdiv_end) begin
                cnt_d   = '0;
                state_d = BS_GAP;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
            end
            // Chaining straight into the next byte keeps CS high for exactly BYTE_GAP cycles.
            BS_GAP: if (gap_end) begin
                o_done = 1'b1;
                cnt_d  = '0;
                if (i_start) begin
                    state_d = BS_CS_SETUP;
                    cs_d    = 1'b0;
                    tx_d    = i_tx_byte;
                end else begin
                    state_d = BS_IDLE;
                end
            end
            default: state_d = BS_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= BS_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b1;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    assign o_rx_byte = rx_q;
    assign o_sclk    = sclk_q;
    assign o_cs      = cs_q;
    assign o_mosi    = mosi_q;
endmodule

// File: rtl/spi_wb_host.sv
// SPI host for the spiwishbone bridge: sequences one 32-bit read/write frame byte by byte.
module spi_wb_host
    import spi_wb_host_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int BYTE_GAP = 4,
    parameter int RD_LEAD  = 2,
    parameter int WR_TAIL  = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    spi_wb_host_if.slave  cmd,
    output logic          o_spi_clk,
    output logic          o_spi_cs,
    output logic          o_spi_mosi,
    input  logic          i_spi_miso
);
    localparam int RD_LAST = IDX_DATA + RD_LEAD + 3;
    localparam int WR_LAST = IDX_DATA + 3 + WR_TAIL;

    if (RD_LEAD + 11 > 15 || WR_TAIL + 11 > 15) begin : g_len_chk
        $error("spi_wb_host: frame does not fit the 4-bit byte index");
    end
    if (CLK_DIV < 2 || BYTE_GAP < 1) begin : g_div_chk
        $error("spi_wb_host: CLK_DIV must be >= 2 and BYTE_GAP >= 1");
    end

    logic        busy_q, busy_d, rsp_q, rsp_d, kick_q, kick_d, we_q, we_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] adr_q, adr_d, wdata_q, wdata_d, acc_q, acc_d, rdata_q, rdata_d;
    logic        accept, last_byte, start, done;
    logic [3:0]  sel_idx;
    logic [7:0]  tx_byte, rx_byte;

    assign cmd.cmd_ready = ~busy_q & ~rsp_q;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign last_byte     = (idx_q == (we_q ? 4'(WR_LAST) : 4'(RD_LAST)));
    assign start         = kick_q | (done & ~last_byte);
    // The shifter loads the next byte in the same cycle it reports done.
    assign sel_idx       = kick_q ? idx_q : idx_q + 4'd1;
    assign tx_byte       = frame_byte(sel_idx, we_q, adr_q, wdata_q);

    always_comb begin
        busy_d  = busy_q;
        rsp_d   = 1'b0;
        kick_d  = 1'b0;
        we_d    = we_q;
        idx_d   = idx_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        if (accept) begin
            busy_d  = 1'b1;
            kick_d  = 1'b1;
            we_d    = cmd.cmd_we;
            adr_d   = cmd.cmd_adr;
            wdata_d = cmd.cmd_wdata;
            idx_d   = '0;
        end
        if (done) begin
            idx_d = idx_q + 4'd1;
            // Right-shift in each received byte so the first data byte ends up in [7:0].
            acc_d = {rx_byte, acc_q[31:8]};
            if (last_byte) begin
                busy_d = 1'b0;
                rsp_d  = 1'b1;
                if (!we_q) rdata_d = {rx_byte, acc_q[31:8]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q  <= 1'b0;
            rsp_q   <= 1'b0;
            kick_q  <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rsp_q   <= rsp_d;
            kick_q  <= kick_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    assign cmd.busy      = busy_q;
    assign cmd.rsp_valid = rsp_q;
    assign cmd.rsp_we    = we_q;
    assign cmd.rdata     = rdata_q;

    spi_byte_shifter #(
        .CLK_DIV  (CLK_DIV),
        .BYTE_GAP (BYTE_GAP)
    ) u_shifter (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (start),
        .i_tx_byte (tx_byte),
        .i_miso    (i_spi_miso),
        .o_rx_byte (rx_byte),
        .o_done    (done),
        .o_sclk    (o_spi_clk),
        .o_cs      (o_spi_cs),
        .o_mosi    (o_spi_mosi)
    );
endmodule

// File: tb/tb_spi_wb_host.sv
// Directed bench for spi_wb_host: an SPI slave monitor/MISO model checks frames and timing.
module tb_spi_wb_host;
    localparam int CLK_DIV = 4, BYTE_GAP = 4, RD_LEAD = 2, WR_TAIL = 1;

    logic i_clk = 1'b0, i_reset = 1'b1, i_spi_miso = 1'b0;
    logic o_spi_clk, o_spi_cs, o_spi_mosi;

    spi_wb_host_if cmd_if();

    spi_wb_host #(.CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .RD_LEAD(RD_LEAD), .WR_TAIL(WR_TAIL)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .cmd        (cmd_if),
        .o_spi_clk  (o_spi_clk),
        .o_spi_cs   (o_spi_cs),
        .o_spi_mosi (o_spi_mosi),
        .i_spi_miso (i_spi_miso)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Monitor / slave model state, sampled on the falling i_clk edge.
    int cyc = 0, mosi_t = 0, rise_t = 0, cs_rise_t = 0;
    bit have_cs_rise = 0;
    int bitk = 0, fk = 0, ncs = 0, nrise = 0, nrsp = 0, naccept = 0;
    int setup_viol = 0, per_viol = 0, gap_viol = 0, idle_viol = 0, ready_viol = 0;
    logic [7:0] rx_sh = '0, miso_byte = '0;
    logic [7:0] mosi_bytes[$];
    logic [7:0] exp_q[$];
    logic [7:0] miso_tbl[16];
    logic sclk_p = 1'b1, cs_p = 1'b1, mosi_p = 1'b0;
    logic last_we = 1'b0;
    logic [31:0] last_rdata = '0;

    always @(negedge i_clk) begin
        cyc++;
        if (o_spi_mosi !== mosi_p) mosi_t = cyc;
        if (o_spi_cs && !o_spi_clk) idle_viol++;
        if (cmd_if.busy && cmd_if.cmd_ready) ready_viol++;
        if (cmd_if.cmd_valid && cmd_if.cmd_ready && !i_reset) naccept++;
        if (cmd_if.rsp_valid) begin
            nrsp++;
            last_we = cmd_if.rsp_we;
            last_rdata = cmd_if.rdata;
            have_cs_rise = 0;
        end
        if (!o_spi_cs && cs_p) begin
            if (have_cs_rise && (cyc - cs_rise_t != BYTE_GAP)) gap_viol++;
            bitk = 0; fk = 0; rx_sh = '0;
            miso_byte = miso_tbl[ncs % 16];
            ncs++;
        end
        if (o_spi_clk && !sclk_p && !o_spi_cs) begin
            nrise++;
            if (cyc - mosi_t < CLK_DIV) setup_viol++;
            if (bitk > 0 && (cyc - rise_t != 2*CLK_DIV)) per_viol++;
            rise_t = cyc;
            rx_sh = {rx_sh[6:0], o_spi_mosi};
            bitk++;
        end
        if (!o_spi_clk && sclk_p && !o_spi_cs && fk < 8) begin
            i_spi_miso = miso_byte[7-fk];
            fk++;
        end
        if (o_spi_cs && !cs_p) begin
            mosi_bytes.push_back(rx_sh);
            cs_rise_t = cyc;
            have_cs_rise = 1;
        end
        sclk_p = o_spi_clk;
        cs_p = o_spi_cs;
        mosi_p = o_spi_mosi;
    end

    task automatic clear_mon();
        mosi_bytes.delete();
        ncs = 0; nrise = 0; naccept = 0; have_cs_rise = 0;
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] wdata);
        @(posedge i_clk); #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_we = we;
        cmd_if.cmd_adr = adr;
        cmd_if.cmd_wdata = wdata;
        @(posedge i_clk); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        int k = 0;
        while (nrsp <= n0 && k < 4000) begin
            @(posedge i_clk); #1;
            k++;
        end
        check("rsp_seen", 32'(nrsp > n0), 32'd1);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, mosi_bytes.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < mosi_bytes.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(mosi_bytes[i]), 32'(exp_q[i]));
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_mosi_setup"}, setup_viol, 0);
        check({tag, "_sclk_period"}, per_viol, 0);
        check({tag, "_cs_gap"}, gap_viol, 0);
        check({tag, "_sclk_idle_hi"}, idle_viol, 0);
    endtask

    initial begin
        int n0;
        int k;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_we = 1'b0;
        cmd_if.cmd_adr = '0;
        cmd_if.cmd_wdata = '0;
        foreach (miso_tbl[i]) miso_tbl[i] = 8'h00;

        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_busy", cmd_if.busy, 0);
        check("rst_rsp_valid", cmd_if.rsp_valid, 0);
        check("rst_rsp_we", cmd_if.rsp_we, 0);
        check("rst_rdata", cmd_if.rdata, 0);
        check("rst_sclk", o_spi_clk, 1);
        check("rst_cs", o_spi_cs, 1);
        check("rst_mosi", o_spi_mosi, 0);

        // Write frame
        clear_mon();
        n0 = nrsp;
        send(1'b1, 32'h11223344, 32'h88776655);
        check("wr_busy_after_accept", cmd_if.busy, 1);
        check("wr_ready_after_accept", cmd_if.cmd_ready, 0);
        wait_rsp(n0);
        repeat (20) @(posedge i_clk);
        #1;
        exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h04, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        check_bytes("wr");
        check("wr_cs_windows", ncs, 12);
        check("wr_sclk_rises", nrise, 96);
        check("wr_rsp_count", nrsp - n0, 1);
        check("wr_rsp_we", last_we, 1);
        check("wr_rdata_untouched", last_rdata, 0);

        // Read frame with MISO returning CC DD EE FF in the data bytes
        clear_mon();
        miso_tbl[9] = 8'hCC; miso_tbl[10] = 8'hDD; miso_tbl[11] = 8'hEE; miso_tbl[12] = 8'hFF;
        n0 = nrsp;
        send(1'b0, 32'h55667788, 32'h0);
        wait_rsp(n0);
        repeat (20) @(posedge i_clk);
        #1;
        exp_q = '{8'hA1, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h04,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("rd");
        check("rd_sclk_rises", nrise, 104);
        check("rd_rsp_count", nrsp - n0, 1);
        check("rd_rsp_we", last_we, 0);
        check("rd_rdata", last_rdata, 32'hFFEEDDCC);
        check("rd_rdata_hold", cmd_if.rdata, 32'hFFEEDDCC);
        check_timing("rd");

        // Valid held high: exactly one accept per frame, the next only after rsp_valid
        clear_mon();
        foreach (miso_tbl[i]) miso_tbl[i] = 8'h00;
        n0 = nrsp;
        @(posedge i_clk); #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_we = 1'b1;
        cmd_if.cmd_adr = 32'h00000010;
        cmd_if.cmd_wdata = 32'hA5A5A5A5;
        wait_rsp(n0);
        check("hold_accepts_first", naccept, 1);
        check("hold_ready_after_rsp", cmd_if.cmd_ready, 1);
        @(posedge i_clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("hold_busy_second", cmd_if.busy, 1);
        wait_rsp(n0 + 1);
        check("hold_accepts_total", naccept, 2);
        check("hold_cs_windows", ncs, 24);
        check("hold_ready_while_busy", ready_viol, 0);
        check("hold_rdata_kept", cmd_if.rdata, 32'hFFEEDDCC);

        // Reset during byte 3 of a read
        clear_mon();
        miso_tbl[9] = 8'hCC; miso_tbl[10] = 8'hDD; miso_tbl[11] = 8'hEE; miso_tbl[12] = 8'hFF;
        send(1'b0, 32'h55667788, 32'h0);
        k = 0;
        while (ncs < 4 && k < 2000) begin
            @(posedge i_clk); #1;
            k++;
        end
        check("rst_mid_reached_byte3", 32'(ncs >= 4), 1);
        repeat (10) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk); #1;
        check("rstmid_cs", o_spi_cs, 1);
        check("rstmid_sclk", o_spi_clk, 1);
        check("rstmid_busy", cmd_if.busy, 0);
        check("rstmid_rsp_valid", cmd_if.rsp_valid, 0);
        check("rstmid_rdata", cmd_if.rdata, 0);
        i_reset = 1'b0;
        n0 = nrsp;
        repeat (300) @(posedge i_clk);
        #1;
        check("rstmid_no_rsp", nrsp - n0, 0);

        // Write after the aborted read
        clear_mon();
        n0 = nrsp;
        send(1'b1, 32'hDEADBEEF, 32'h01020304);
        wait_rsp(n0);
        repeat (20) @(posedge i_clk);
        #1;
        exp_q = '{8'hA2, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        check_bytes("wr2");
        check("wr2_rsp_we", last_we, 1);
        check("wr2_rdata", cmd_if.rdata, 0);
        check_timing("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
